// File: rtl/rm_feeder_pkg.sv
// ============================================================================
// rm_feeder_pkg : shared types and defaults for the runtime-monitor symbol feeder
// Revision      : 1.0
// ============================================================================
`default_nettype none

package rm_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST    = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int RST_CYCLES_DEF = 2;
  localparam int RPT_VEC_W      = 4;
  localparam int RPT_TS_W       = 32;

  // Report widths are fixed here; the top-level parameters default to them.
  typedef struct packed {
    logic [RPT_VEC_W-1:0] vec;
    logic [RPT_TS_W-1:0]  ts;
  } report_t;

endpackage

`default_nettype wire

// File: rtl/rm_sync_fifo.sv
// ============================================================================
// rm_sync_fifo : single-clock FIFO with wrap-bit pointers and synchronous flush
// Revision     : 1.0
// ============================================================================
`default_nettype none

module rm_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Equal indices with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/rm_symbol_feeder.sv
// ============================================================================
// rm_symbol_feeder : buffers probe symbols, sequences automaton reset/run and
//                    returns tagged non-zero automaton reports
// Revision         : 1.0
// ============================================================================
`default_nettype none

module rm_symbol_feeder
  import rm_feeder_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SYM_W      = 8,
  parameter int N_REPORT   = RPT_VEC_W,
  parameter int TS_W       = RPT_TS_W,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trace_start,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [SYM_W-1:0]    ev_props,
  output logic                am_reset,
  output logic                am_run,
  output logic [SYM_W-1:0]    am_symbols,
  input  logic [N_REPORT-1:0] am_reports,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [N_REPORT-1:0] rpt_vec,
  output logic [TS_W-1:0]     rpt_ts,
  output logic                rpt_lost
);

  localparam int CW = $clog2(RST_CYCLES) + 1;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   rst_cnt;
  logic [CW-1:0]   rst_cnt_nx;
  logic            restart;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [SYM_W-1:0] fifo_head;
  logic [TS_W-1:0] sym_idx;
  logic            samp_valid;
  logic [TS_W-1:0] samp_ts;
  report_t         rpt_q;

  assign restart  = trace_start;
  assign ev_ready = (state == STREAM) && !fifo_full && !trace_start;
  assign push     = ev_valid && ev_ready;
  assign pop      = (state == STREAM) && !fifo_empty && !trace_start;
  // Reset is OR-ed in so the automaton sees reset the instant it is asserted.
  assign am_reset = reset || (state == RST);
  assign rpt_vec  = rpt_q.vec;
  assign rpt_ts   = rpt_q.ts;

  rm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (restart),
    .wr_data (ev_props),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rst_cnt <= '0;
    end else begin
      state   <= state_nx;
      rst_cnt <= rst_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    if (trace_start) begin
      state_nx   = RST;
      rst_cnt_nx = '0;
    end else begin
      case (state)
        RST: begin
          if (rst_cnt == CW'(RST_CYCLES - 1)) state_nx = STREAM;
          else                                 rst_cnt_nx = rst_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      am_run     <= 1'b0;
      am_symbols <= '0;
      sym_idx    <= '0;
      samp_valid <= 1'b0;
      samp_ts    <= '0;
      rpt_valid  <= 1'b0;
      rpt_q      <= '0;
      rpt_lost   <= 1'b0;
    end else if (restart) begin
      am_run     <= 1'b0;
      sym_idx    <= '0;
      samp_valid <= 1'b0;
      samp_ts    <= '0;
      rpt_valid  <= 1'b0;
      rpt_lost   <= 1'b0;
    end else begin
      am_run <= pop;
      if (pop) am_symbols <= fifo_head;
      if (am_run) sym_idx <= sym_idx + 1'b1;
      // The automaton answers one cycle after consuming a symbol.
      samp_valid <= am_run;
      samp_ts    <= sym_idx;
      if (samp_valid && (|am_reports)) begin
        if (!rpt_valid || rpt_ready) begin
          rpt_valid <= 1'b1;
          rpt_q.vec <= am_reports;
          rpt_q.ts  <= samp_ts;
        end else begin
          rpt_lost  <= 1'b1;
        end
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rm_symbol_feeder.sv
// ============================================================================
// tb_rm_symbol_feeder : vector table, directed corner sequences and a random
//                       run against a queue-based reference model
// Revision            : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rm_symbol_feeder;

  localparam int DEPTH      = 8;
  localparam int SYM_W      = 8;
  localparam int N_REPORT   = 4;
  localparam int TS_W       = 32;
  localparam int RST_CYCLES = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                trace_start = 1'b0;
  logic                ev_valid = 1'b0;
  logic [SYM_W-1:0]    ev_props = '0;
  logic [N_REPORT-1:0] am_reports = '0;
  logic                rpt_ready = 1'b1;
  logic                ev_ready;
  logic                am_reset;
  logic                am_run;
  logic [SYM_W-1:0]    am_symbols;
  logic                rpt_valid;
  logic [N_REPORT-1:0] rpt_vec;
  logic [TS_W-1:0]     rpt_ts;
  logic                rpt_lost;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rm_symbol_feeder #(
    .DEPTH(DEPTH), .SYM_W(SYM_W), .N_REPORT(N_REPORT), .TS_W(TS_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .trace_start(trace_start),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_props(ev_props),
    .am_reset(am_reset), .am_run(am_run), .am_symbols(am_symbols), .am_reports(am_reports),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec), .rpt_ts(rpt_ts),
    .rpt_lost(rpt_lost)
  );

  typedef struct {
    logic       ts;
    logic       ev;
    logic [7:0] props;
    logic       exp_rst;
    logic       exp_rdy;
    logic       exp_run;
    logic [7:0] exp_sym;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic ts, input logic ev, input logic [7:0] props,
                      input logic [3:0] reps, input logic rr);
    @(posedge clk);
    #1;
    trace_start = ts;
    ev_valid    = ev;
    ev_props    = props;
    am_reports  = reps;
    rpt_ready   = rr;
    @(negedge clk);
  endtask

  // Reference model state for the random phase
  logic [7:0]  mq[$];
  logic        m_run, m_samp, m_rv, m_lost;
  logic [7:0]  m_sym;
  logic [3:0]  m_vec;
  logic [31:0] m_idx, m_samp_ts, m_ts;
  logic [7:0]  got[$];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h10};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h80};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80};

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset am_reset", 32'(am_reset), 1);
    chk("reset ev_ready", 32'(ev_ready), 0);
    chk("reset am_run", 32'(am_run), 0);
    chk("reset am_symbols", 32'(am_symbols), 0);
    chk("reset rpt_valid", 32'(rpt_valid), 0);
    chk("reset rpt_vec", 32'(rpt_vec), 0);
    chk("reset rpt_ts", rpt_ts, 0);
    chk("reset rpt_lost", 32'(rpt_lost), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle am_reset", 32'(am_reset), 0);

    // Sequence check: trace_start at cycle 5, then 0x10/0x20/0x80
    for (int c = 0; c < 14; c++) begin
      step(tbl[c].ts, tbl[c].ev, tbl[c].props, 4'h0, 1'b1);
      chk($sformatf("seq c%0d am_reset", c), 32'(am_reset), 32'(tbl[c].exp_rst));
      chk($sformatf("seq c%0d ev_ready", c), 32'(ev_ready), 32'(tbl[c].exp_rdy));
      chk($sformatf("seq c%0d am_run", c), 32'(am_run), 32'(tbl[c].exp_run));
      chk($sformatf("seq c%0d am_symbols", c), 32'(am_symbols), 32'(tbl[c].exp_sym));
    end

    // Report capture on the symbol of index 3
    step(1'b0, 1'b1, 8'h33, 4'h0, 1'b1);
    chk("cap ev_ready", 32'(ev_ready), 1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("cap am_run", 32'(am_run), 1);
    chk("cap am_symbols", 32'(am_symbols), 32'h33);
    step(1'b0, 1'b0, 8'h00, 4'b0100, 1'b1);
    chk("cap rpt_valid early", 32'(rpt_valid), 0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("cap rpt_valid", 32'(rpt_valid), 1);
    chk("cap rpt_vec", 32'(rpt_vec), 32'b0100);
    chk("cap rpt_ts", rpt_ts, 3);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("cap rpt_valid drained", 32'(rpt_valid), 0);

    // Report stall: two reports with rpt_ready low
    step(1'b0, 1'b1, 8'h41, 4'h0, 1'b0);
    step(1'b0, 1'b1, 8'h42, 4'h0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    chk("stall run 41", 32'(am_symbols), 32'h41);
    step(1'b0, 1'b0, 8'h00, 4'b0001, 1'b0);
    chk("stall run 42", 32'(am_symbols), 32'h42);
    step(1'b0, 1'b0, 8'h00, 4'b0010, 1'b0);
    chk("stall first valid", 32'(rpt_valid), 1);
    chk("stall first ts", rpt_ts, 4);
    chk("stall lost early", 32'(rpt_lost), 0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    chk("stall held valid", 32'(rpt_valid), 1);
    chk("stall held vec", 32'(rpt_vec), 32'b0001);
    chk("stall held ts", rpt_ts, 4);
    chk("stall lost", 32'(rpt_lost), 1);
    step(1'b1, 1'b1, 8'h99, 4'h0, 1'b0);
    chk("restart ev_ready gated", 32'(ev_ready), 0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    chk("restart rpt_valid clr", 32'(rpt_valid), 0);
    chk("restart rpt_lost clr", 32'(rpt_lost), 0);
    chk("restart am_reset 1", 32'(am_reset), 1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("restart am_reset 2", 32'(am_reset), 1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("restart am_reset off", 32'(am_reset), 0);
    chk("restart ev_ready", 32'(ev_ready), 1);

    // Backpressure: hold the FIFO closed so it fills
    force dut.pop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + i), 4'h0, 1'b1);
      chk($sformatf("bp fill %0d ev_ready", i), 32'(ev_ready), 1);
    end
    step(1'b0, 1'b1, 8'hEE, 4'h0, 1'b1);
    chk("bp full ev_ready", 32'(ev_ready), 0);
    @(posedge clk);
    #1 release dut.pop;
    @(negedge clk);
    chk("bp pop-cycle ev_ready", 32'(ev_ready), 0);
    got.delete();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
      if (am_run) got.push_back(am_symbols);
    end
    chk("bp emerged count", got.size(), DEPTH);
    for (int k = 0; k < got.size() && k < DEPTH; k++)
      chk($sformatf("bp order %0d", k), 32'(got[k]), 32'(8'hA0 + k));

    // Restart with five entries buffered
    force dut.pop = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 4'h0, 1'b1);
    @(posedge clk);
    #1;
    release dut.pop;
    trace_start = 1'b1;
    ev_valid    = 1'b1;
    ev_props    = 8'hDD;
    @(negedge clk);
    chk("rs ev_ready gated", 32'(ev_ready), 0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
      chk($sformatf("rs rst %0d am_run", k), 32'(am_run), 0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
      chk($sformatf("rs stream %0d am_run", k), 32'(am_run), 0);
    end
    step(1'b0, 1'b1, 8'h5A, 4'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("rs new am_run", 32'(am_run), 1);
    chk("rs new symbol", 32'(am_symbols), 32'h5A);
    step(1'b0, 1'b0, 8'h00, 4'b1000, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    chk("rs rpt_valid", 32'(rpt_valid), 1);
    chk("rs rpt_ts", rpt_ts, 0);

    // Random phase from a clean trace
    step(1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    mq.delete();
    m_run = 0; m_samp = 0; m_rv = 0; m_lost = 0; m_sym = '0;
    m_vec = '0; m_idx = '0; m_samp_ts = '0; m_ts = '0;
    for (int c = 0; c < 400; c++) begin
      logic       v, rr, exp_rdy;
      logic [7:0] p;
      logic [3:0] r;
      v  = ($urandom_range(0, 9) < 7);
      p  = 8'($urandom);
      r  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      rr = 1'($urandom_range(0, 1));
      step(1'b0, v, p, r, rr);
      exp_rdy = (mq.size() < DEPTH);
      chk("rnd ev_ready", 32'(ev_ready), 32'(exp_rdy));
      chk("rnd am_run", 32'(am_run), 32'(m_run));
      if (m_run) chk("rnd am_symbols", 32'(am_symbols), 32'(m_sym));
      chk("rnd rpt_valid", 32'(rpt_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rnd rpt_vec", 32'(rpt_vec), 32'(m_vec));
        chk("rnd rpt_ts", rpt_ts, m_ts);
      end
      chk("rnd rpt_lost", 32'(rpt_lost), 32'(m_lost));
      if (m_samp && r != 4'h0) begin
        if (!m_rv || rr) begin
          m_rv = 1; m_vec = r; m_ts = m_samp_ts;
        end else begin
          m_lost = 1;
        end
      end else if (m_rv && rr) begin
        m_rv = 0;
      end
      m_samp    = m_run;
      m_samp_ts = m_idx;
      if (m_run) m_idx = m_idx + 1;
      if (mq.size() > 0) begin
        m_run = 1;
        m_sym = mq.pop_front();
      end else begin
        m_run = 0;
      end
      if (v && exp_rdy) mq.push_back(p);
    end

    // Asynchronous reset while streaming with a report held
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b0, 1'b1, 8'h71, 4'h0, 1'b0);
    step(1'b0, 1'b1, 8'h72, 4'h0, 1'b0);
    step(1'b0, 1'b1, 8'h73, 4'h0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'b0010, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    chk("arst pre am_run", 32'(am_run), 1);
    chk("arst pre rpt_valid", 32'(rpt_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst am_run", 32'(am_run), 0);
    chk("arst rpt_valid", 32'(rpt_valid), 0);
    chk("arst am_reset", 32'(am_reset), 1);
    chk("arst ev_ready", 32'(ev_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
